pio_master: RTL and testbench
=============================

Name: pio_master

Overview:
- PIO bus initiator: the requester end of the reg_bs/reg_rd/reg_wr register bus that block register files respond to.
- Accepts read/write commands from a local command port and queues them in a small FIFO.
- Drives one bus transaction at a time and waits for the completion handshake (pio_ack for writes, pio_rvalid for reads).
- Returns a response (read data or error) on a valid/ready response port, with timeout protection against absent responders.

Parameters:
- PIO_NBITS, 32, address/data width of the PIO bus.
- CMD_DEPTH, 4, command FIFO depth; power of 2, minimum 2.
- TO_CYCLES, 1023, clk cycles to wait for a completion before declaring timeout.
- TO_NBITS, 10, timeout counter width; must satisfy 2^TO_NBITS > TO_CYCLES.

Ports:
- clk  in  1  core clock
- rstn  in  1  asynchronous reset, active low
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_wr  in  1  1=write, 0=read
- cmd_addr  in  PIO_NBITS  register address
- cmd_wdata  in  PIO_NBITS  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_wr  out  1  echo of cmd_wr
- rsp_err  out  1  1=timeout
- rsp_rdata  out  PIO_NBITS  read data; 0 for writes and errors
- reg_bs  out  1  bus select, held for the whole transaction
- reg_rd  out  1  one-cycle read strobe
- reg_wr  out  1  one-cycle write strobe
- reg_addr  out  PIO_NBITS  held for the whole transaction
- reg_din  out  PIO_NBITS  held for the whole transaction
- pio_ack  in  1  write completion
- pio_rvalid  in  1  read completion
- pio_rdata  in  PIO_NBITS  read data, sampled when pio_rvalid=1

Behaviour:
- Reset values: cmd_ready=1, and all other outputs 0. Reset clears the FIFO, the FSM (forced to IDLE) and the timeout counter. Reset mid-transaction drops reg_bs immediately and loses the command.
- FIFO push when cmd_valid&cmd_ready. cmd_ready=0 when CMD_DEPTH entries are held. Pointers wrap modulo CMD_DEPTH. A push and a pop in the same cycle are both performed.
- FSM states: IDLE, ISSUE, WAIT, RESP, GAP.
- IDLE: if the FIFO is not empty, load the head entry into the bus registers and go to ISSUE. The head entry is popped at this point.
- ISSUE (1 cycle):
  - reg_bs=1, reg_addr/reg_din driven.
  - reg_rd=1 for a read or reg_wr=1 for a write; exactly one strobe, exactly one cycle.
  - Load the timeout counter with TO_CYCLES; go to WAIT.
- WAIT:
  - reg_bs, reg_addr and reg_din stay stable; no strobe is driven.
  - Read completes on pio_rvalid: capture pio_rdata, rsp_err=0.
  - Write completes on pio_ack; pio_rvalid is ignored for writes.
  - pio_ack is ignored for reads.
  - Counter decrements each cycle. When it reaches 0 with no completion: rsp_err=1, rsp_rdata=0.
  - A completion in the same cycle as counter==0 is a success (completion wins).
  - On completion or timeout: deassert reg_bs, go to RESP.
  - Minimum latency is strobe to completion sampled in the following cycle, so ISSUE to rsp_valid is at least 2 cycles.
- RESP: rsp_valid=1 with rsp_wr/rsp_err/rsp_rdata stable until rsp_ready. When rsp_valid&rsp_ready, go to GAP. rsp_ready is allowed to be high before rsp_valid.
- GAP: reg_bs=0. Remain here until pio_ack=0 and pio_rvalid=0 (minimum 1 cycle), then go to IDLE. This guarantees the previous responder's stale ack/rvalid is never seen by the next transaction.
- Only one outstanding bus transaction at any time. Commands complete in order.
- Responses from a late responder arriving after a timeout are absorbed in GAP and discarded.
- The responder may sample the strobe only on its divided-clock enable; the master holds reg_bs, not the strobe, so no clk_div input is required.

Optional Feature:
- Macro: PIO_MASTER_STATS_EN.
- Defined: adds outputs stat_txn_cnt[15:0] and stat_to_cnt[15:0].
  - stat_txn_cnt increments on each RESP handshake.
  - stat_to_cnt increments on each timeout.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: these ports and their counters are absent; all other behaviour is identical.

Test Plan:
- Write addr=0x10, data=0x1234; responder asserts pio_ack 3 cycles after reg_wr -> exactly one reg_wr pulse, reg_bs high for 4 cycles, then rsp_valid with rsp_wr=1, rsp_err=0, rsp_rdata=0.
- Read addr=0x14; responder returns pio_rvalid with pio_rdata=0xCAFE after 5 cycles -> rsp_rdata=0xCAFE, rsp_err=0, and no reg_wr seen.
- Read to an unmapped address with no responder, TO_CYCLES=1023 -> reg_bs drops after 1024 WAIT cycles, then rsp_err=1 and rsp_rdata=0.
- Push 5 commands back-to-back with rsp_ready held low -> cmd_ready drops after 4 entries are queued. Releasing rsp_ready lets all 5 complete in order, with a gap of at least 1 cycle with reg_bs=0 between transactions.
- pio_ack held high 2 cycles after a write completes -> the next transaction's ISSUE is delayed until pio_ack=0.
- Assert rstn=0 during WAIT -> reg_bs=0 immediately, FIFO empty, cmd_ready=1, and no response is emitted after reset release.

Source files
------------

// File: rtl/pio_master_if.sv
// PIO master bundle: local command/response ports plus the reg_bs/reg_rd/reg_wr register bus.
// The master modport is the initiator's view. The slave modport is the view of the environment around it.
interface pio_master_if #(
  parameter int PIO_NBITS = 32
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic                 cmd_wr;
  logic [PIO_NBITS-1:0] cmd_addr;
  logic [PIO_NBITS-1:0] cmd_wdata;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_wr;
  logic                 rsp_err;
  logic [PIO_NBITS-1:0] rsp_rdata;

  logic                 reg_bs;
  logic                 reg_rd;
  logic                 reg_wr;
  logic [PIO_NBITS-1:0] reg_addr;
  logic [PIO_NBITS-1:0] reg_din;
  logic                 pio_ack;
  logic                 pio_rvalid;
  logic [PIO_NBITS-1:0] pio_rdata;

  modport master (
    input  cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
    input  pio_ack, pio_rvalid, pio_rdata,
    output cmd_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata,
    output reg_bs, reg_rd, reg_wr, reg_addr, reg_din
  );

  modport slave (
    output cmd_valid, cmd_wr, cmd_addr, cmd_wdata, rsp_ready,
    output pio_ack, pio_rvalid, pio_rdata,
    input  cmd_ready, rsp_valid, rsp_wr, rsp_err, rsp_rdata,
    input  reg_bs, reg_rd, reg_wr, reg_addr, reg_din
  );
endinterface

// File: rtl/pio_master.sv
// PIO bus initiator: queues commands, runs one register-bus transaction at a time with timeout.
// Optional macro PIO_MASTER_STATS_EN adds saturating transaction and timeout counters.
//
// state | meaning
// IDLE  | wait for a queued command, pop it into the bus registers
// ISSUE | reg_bs plus a single-cycle reg_rd or reg_wr strobe, arm the timeout
// WAIT  | hold the bus until completion or timeout
// RESP  | present the response until rsp_ready
// GAP   | bus idle until the last responder drops ack/rvalid
module pio_master #(
  parameter int PIO_NBITS = 32,
  parameter int CMD_DEPTH = 4,
  parameter int TO_CYCLES = 1023,
  parameter int TO_NBITS  = 10
) (
  input  logic        clk,
  input  logic        rstn,
`ifdef PIO_MASTER_STATS_EN
  output logic [15:0] stat_txn_cnt,
  output logic [15:0] stat_to_cnt,
`endif
  pio_master_if.master bus
);

  localparam int            AW     = $clog2(CMD_DEPTH);
  localparam logic [AW:0]   L_FULL = (AW+1)'(CMD_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t r_state, w_next;

  logic                 r_fifo_wr   [CMD_DEPTH];
  logic [PIO_NBITS-1:0] r_fifo_addr [CMD_DEPTH];
  logic [PIO_NBITS-1:0] r_fifo_din  [CMD_DEPTH];
  logic [AW-1:0]        r_wptr, r_rptr;
  logic [AW:0]          r_count;

  logic                 r_wr;
  logic [PIO_NBITS-1:0] r_addr;
  logic [PIO_NBITS-1:0] r_din;
  logic                 r_err;
  logic [PIO_NBITS-1:0] r_rdata;
  logic [TO_NBITS-1:0]  r_to_cnt;

  logic w_cmd_ready, w_empty, w_push, w_pop, w_done, w_timeout;

  assign w_cmd_ready = (r_count != L_FULL);
  assign w_empty     = (r_count == '0);
  assign w_push      = bus.cmd_valid & w_cmd_ready;
  assign w_pop       = (r_state == S_IDLE) & ~w_empty;
  // Only the completion matching the issued direction counts.
  assign w_done      = (r_state == S_WAIT) & (r_wr ? bus.pio_ack : bus.pio_rvalid);
  assign w_timeout   = (r_state == S_WAIT) & ~w_done & (r_to_cnt == '0);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_wr[r_wptr]   <= bus.cmd_wr;
      r_fifo_addr[r_wptr] <= bus.cmd_addr;
      r_fifo_din[r_wptr]  <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!w_empty) w_next = S_ISSUE;
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (w_done || w_timeout) w_next = S_RESP;
      S_RESP:  if (bus.rsp_ready) w_next = S_GAP;
      S_GAP:   if (!bus.pio_ack && !bus.pio_rvalid) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = w_cmd_ready;
    bus.reg_bs    = 1'b0;
    bus.reg_rd    = 1'b0;
    bus.reg_wr    = 1'b0;
    bus.reg_addr  = r_addr;
    bus.reg_din   = r_din;
    bus.rsp_valid = 1'b0;
    bus.rsp_wr    = r_wr;
    bus.rsp_err   = r_err;
    bus.rsp_rdata = r_rdata;
    unique case (r_state)
      S_ISSUE: begin
        bus.reg_bs = 1'b1;
        bus.reg_rd = ~r_wr;
        bus.reg_wr = r_wr;
      end
      S_WAIT:  bus.reg_bs    = 1'b1;
      S_RESP:  bus.rsp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
      r_to_cnt <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_wr   <= r_fifo_wr[r_rptr];
            r_addr <= r_fifo_addr[r_rptr];
            r_din  <= r_fifo_din[r_rptr];
          end
        end
        S_ISSUE: r_to_cnt <= TO_NBITS'(TO_CYCLES);
        S_WAIT: begin
          if (w_done) begin
            r_err   <= 1'b0;
            r_rdata <= r_wr ? '0 : bus.pio_rdata;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
          end else begin
            r_to_cnt <= r_to_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIO_MASTER_STATS_EN
  logic [15:0] r_stat_txn, r_stat_to;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_txn <= '0;
      r_stat_to  <= '0;
    end else begin
      if (r_state == S_RESP && bus.rsp_ready && r_stat_txn != 16'hFFFF)
        r_stat_txn <= r_stat_txn + 1'b1;
      if (w_timeout && r_stat_to != 16'hFFFF)
        r_stat_to <= r_stat_to + 1'b1;
    end
  end

  assign stat_txn_cnt = r_stat_txn;
  assign stat_to_cnt  = r_stat_to;
`endif

endmodule

// File: tb/tb_pio_master.sv
// Directed bench for pio_master: vector table of single transactions plus queueing, gap and reset sequences.
module tb_pio_master;
  localparam int NB = 32;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pio_master_if #(.PIO_NBITS(NB)) bus();

`ifdef PIO_MASTER_STATS_EN
  logic [15:0] stat_txn_cnt, stat_to_cnt;
`endif

  pio_master #(.PIO_NBITS(NB), .CMD_DEPTH(4), .TO_CYCLES(1023), .TO_NBITS(10)) dut (
    .clk  (clk),
    .rstn (rstn),
`ifdef PIO_MASTER_STATS_EN
    .stat_txn_cnt (stat_txn_cnt),
    .stat_to_cnt  (stat_to_cnt),
`endif
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // responder: answers a strobe after resp_lat cycles (0 = never), holding the completion resp_hold cycles
  int          resp_lat  = 0;
  int          resp_hold = 1;
  logic        resp_swap = 1'b0;
  logic        resp_xor  = 1'b0;
  logic [31:0] resp_data = 32'h0;

  initial begin
    int          cnt, hold_left;
    logic        is_wr;
    logic [31:0] data;
    cnt = 0; hold_left = 0; is_wr = 1'b0; data = 32'h0;
    bus.pio_ack = 1'b0; bus.pio_rvalid = 1'b0; bus.pio_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rstn) begin
        cnt = 0; hold_left = 0;
        bus.pio_ack = 1'b0; bus.pio_rvalid = 1'b0; bus.pio_rdata = '0;
      end else begin
        if (hold_left > 0) begin
          hold_left--;
          if (hold_left == 0) begin
            bus.pio_ack = 1'b0; bus.pio_rvalid = 1'b0; bus.pio_rdata = '0;
          end
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            if (is_wr ^ resp_swap) bus.pio_ack = 1'b1;
            else begin
              bus.pio_rvalid = 1'b1;
              bus.pio_rdata  = data;
            end
            hold_left = resp_hold;
          end
        end
        if ((bus.reg_rd || bus.reg_wr) && resp_lat > 0) begin
          is_wr = bus.reg_wr;
          data  = resp_xor ? (resp_data ^ bus.reg_addr) : resp_data;
          cnt   = resp_lat;
        end
      end
    end
  end

  // bus monitor
  int          bs_cycles = 0, wr_pulses = 0, rd_pulses = 0, addr_unstable = 0;
  int          low_cnt = 0, last_gap = 0;
  logic [31:0] issued_addr[$];
  logic [31:0] issued_din[$];

  initial begin
    logic        prev_bs;
    logic [31:0] prev_addr, prev_din;
    prev_bs = 1'b0; prev_addr = 32'h0; prev_din = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.reg_bs) begin
        bs_cycles++;
        if (!prev_bs) begin
          last_gap = low_cnt;
          issued_addr.push_back(bus.reg_addr);
          issued_din.push_back(bus.reg_din);
        end else if (bus.reg_addr !== prev_addr || bus.reg_din !== prev_din) begin
          addr_unstable++;
        end
        low_cnt = 0;
      end else begin
        low_cnt++;
      end
      if (bus.reg_wr) wr_pulses++;
      if (bus.reg_rd) rd_pulses++;
      prev_bs = bus.reg_bs; prev_addr = bus.reg_addr; prev_din = bus.reg_din;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_rsp(input string name, input int budget);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, " rsp_valid arrives"}, 32'(bus.rsp_valid), 32'd1);
  endtask

  task automatic push_one(input string name, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    bus.cmd_valid = 1'b1;
    bus.cmd_wr    = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    check({name, " cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic collect(input string name, input logic exp_wr, input logic exp_err, input logic [31:0] exp_rdata);
    wait_rsp(name, 1200);
    check({name, " rsp_wr"},    32'(bus.rsp_wr),  32'(exp_wr));
    check({name, " rsp_err"},   32'(bus.rsp_err), 32'(exp_err));
    check({name, " rsp_rdata"}, bus.rsp_rdata,    exp_rdata);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        swap;
    logic [31:0] bus_rdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_bs;
  } vec_t;

  vec_t        vecs[9];
  logic        qa_wr[5];
  logic [31:0] qa_addr[5];
  logic [31:0] qa_rdata[5];

  initial begin
    int base, rsp_seen;

    //          wr    addr        wdata         lat   swap  bus_rdata      err   exp_rdata      bs
    vecs[0] = '{1'b1, 32'h10, 32'h0000_1234,    3, 1'b0, 32'h0,         1'b0, 32'h0,            4};
    vecs[1] = '{1'b0, 32'h14, 32'h0,            5, 1'b0, 32'h0000_CAFE, 1'b0, 32'h0000_CAFE,    6};
    vecs[2] = '{1'b0, 32'h18, 32'h0,            1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF,    2};
    vecs[3] = '{1'b1, 32'h1C, 32'hFFFF_FFFF,    1, 1'b0, 32'h0,         1'b0, 32'h0,            2};
    vecs[4] = '{1'b0, 32'h20, 32'h0,            0, 1'b0, 32'h0,         1'b1, 32'h0,         1025};
    vecs[5] = '{1'b1, 32'h24, 32'h0000_0055,    2, 1'b1, 32'h0000_0777, 1'b1, 32'h0,         1025};
    vecs[6] = '{1'b0, 32'h28, 32'h0,            2, 1'b1, 32'h0000_0999, 1'b1, 32'h0,         1025};
    vecs[7] = '{1'b0, 32'h2C, 32'h0,         1024, 1'b0, 32'h0BAD_F00D, 1'b0, 32'h0BAD_F00D, 1025};
    vecs[8] = '{1'b1, 32'h30, 32'h0000_00AA, 1025, 1'b0, 32'h0,         1'b1, 32'h0,         1025};

    qa_wr[0] = 1'b1; qa_addr[0] = 32'h40; qa_rdata[0] = 32'h0;
    qa_wr[1] = 1'b0; qa_addr[1] = 32'h44; qa_rdata[1] = 32'hB000_0044;
    qa_wr[2] = 1'b1; qa_addr[2] = 32'h48; qa_rdata[2] = 32'h0;
    qa_wr[3] = 1'b0; qa_addr[3] = 32'h4C; qa_rdata[3] = 32'hB000_004C;
    qa_wr[4] = 1'b0; qa_addr[4] = 32'h50; qa_rdata[4] = 32'hB000_0050;

    bus.cmd_valid = 1'b0; bus.cmd_wr = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.rsp_ready = 1'b0;
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check("reset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset rsp_wr",    32'(bus.rsp_wr),    32'd0);
    check("reset rsp_err",   32'(bus.rsp_err),   32'd0);
    check("reset rsp_rdata", bus.rsp_rdata,      32'd0);
    check("reset reg_bs",    32'(bus.reg_bs),    32'd0);
    check("reset reg_rd",    32'(bus.reg_rd),    32'd0);
    check("reset reg_wr",    32'(bus.reg_wr),    32'd0);
    check("reset reg_addr",  bus.reg_addr,       32'd0);
    check("reset reg_din",   bus.reg_din,        32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // single transactions from the vector table
    for (int i = 0; i < 9; i++) begin
      resp_lat = vecs[i].lat; resp_swap = vecs[i].swap; resp_data = vecs[i].bus_rdata;
      resp_xor = 1'b0; resp_hold = 1;
      bs_cycles = 0; wr_pulses = 0; rd_pulses = 0; addr_unstable = 0;
      base = issued_addr.size();
      push_one($sformatf("v%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_rsp($sformatf("v%0d", i), 1200);
      repeat (2) @(negedge clk);
      check($sformatf("v%0d rsp_valid held", i), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("v%0d rsp_wr", i),    32'(bus.rsp_wr),  32'(vecs[i].wr));
      check($sformatf("v%0d rsp_err", i),   32'(bus.rsp_err), 32'(vecs[i].exp_err));
      check($sformatf("v%0d rsp_rdata", i), bus.rsp_rdata,    vecs[i].exp_rdata);
      check($sformatf("v%0d reg_bs cycles", i), 32'(bs_cycles), 32'(vecs[i].exp_bs));
      check($sformatf("v%0d reg_wr pulses", i), 32'(wr_pulses), 32'(vecs[i].wr));
      check($sformatf("v%0d reg_rd pulses", i), 32'(rd_pulses), 32'(!vecs[i].wr));
      check($sformatf("v%0d bus stable", i),    32'(addr_unstable), 32'd0);
      check($sformatf("v%0d reg_addr", i),
            (issued_addr.size() > base) ? issued_addr[base] : 32'hDEAD_DEAD, vecs[i].addr);
      if (vecs[i].wr)
        check($sformatf("v%0d reg_din", i),
              (issued_din.size() > base) ? issued_din[base] : 32'hDEAD_DEAD, vecs[i].wdata);
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check($sformatf("v%0d rsp_valid after handshake", i), 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
    end

    // five back-to-back commands with responses stalled: FIFO fills, then all drain in order
    resp_lat = 2; resp_hold = 1; resp_swap = 1'b0; resp_xor = 1'b1; resp_data = 32'hB000_0000;
    base = issued_addr.size();
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1; bus.cmd_wr = qa_wr[i]; bus.cmd_addr = qa_addr[i]; bus.cmd_wdata = 32'h100 + i;
      check($sformatf("qA cmd_ready %0d", i), 32'(bus.cmd_ready), 32'd1);
      @(negedge clk);
    end
    check("qA full after 5 pushes", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_wr = 1'b0; bus.cmd_addr = 32'h54;
    repeat (3) @(negedge clk);
    check("qA sixth command blocked", 32'(bus.cmd_ready), 32'd0);
    bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++)
      collect($sformatf("qA rsp %0d", i), qa_wr[i], 1'b0, qa_rdata[i]);
    repeat (20) @(negedge clk);
    check("qA issued count", 32'(issued_addr.size() - base), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("qA order %0d", i),
            (issued_addr.size() > base + i) ? issued_addr[base + i] : 32'hDEAD_DEAD, qa_addr[i]);
    check("qA no extra response", 32'(bus.rsp_valid), 32'd0);

    // lingering pio_ack stretches the idle gap by one cycle
    resp_lat = 1; resp_hold = 3; resp_xor = 1'b0; resp_data = 32'h0;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 32'h60; bus.cmd_wdata = 32'hA;
    @(negedge clk);
    bus.cmd_addr = 32'h64; bus.cmd_wdata = 32'hB;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    collect("gB held0", 1'b1, 1'b0, 32'h0);
    collect("gB held1", 1'b1, 1'b0, 32'h0);
    check("gB gap with ack held", 32'(last_gap), 32'd4);
    resp_hold = 1;
    repeat (4) @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b1; bus.cmd_addr = 32'h68; bus.cmd_wdata = 32'hC;
    @(negedge clk);
    bus.cmd_addr = 32'h6C; bus.cmd_wdata = 32'hD;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    collect("gB short0", 1'b1, 1'b0, 32'h0);
    collect("gB short1", 1'b1, 1'b0, 32'h0);
    check("gB gap with single-cycle ack", 32'(last_gap), 32'd3);
    bus.rsp_ready = 1'b0;
    repeat (4) @(negedge clk);

    // reset during WAIT loses the in-flight and queued commands
    resp_lat = 0;
    bus.cmd_valid = 1'b1; bus.cmd_wr = 1'b0; bus.cmd_addr = 32'h70; bus.cmd_wdata = 32'h0;
    @(negedge clk);
    bus.cmd_wr = 1'b1; bus.cmd_addr = 32'h74; bus.cmd_wdata = 32'h5;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("rC reg_bs in WAIT", 32'(bus.reg_bs), 32'd1);
    rstn = 1'b0;
    #1;
    check("rC reg_bs drops at reset", 32'(bus.reg_bs),    32'd0);
    check("rC cmd_ready at reset",    32'(bus.cmd_ready), 32'd1);
    check("rC rsp_valid at reset",    32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    bs_cycles = 0;
    base = issued_addr.size();
    rsp_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.rsp_valid) rsp_seen++;
    end
    check("rC no response after reset", 32'(rsp_seen), 32'd0);
    check("rC no bus activity",         32'(bs_cycles), 32'd0);
    check("rC no issue after reset",    32'(issued_addr.size() - base), 32'd0);

    resp_lat = 2; resp_data = 32'h1357_9BDF;
    push_one("rC post", 1'b0, 32'h78, 32'h0);
    collect("rC post", 1'b0, 1'b0, 32'h1357_9BDF);
    bus.rsp_ready = 1'b0;
    repeat (4) @(negedge clk);

`ifdef PIO_MASTER_STATS_EN
    check("stat_txn_cnt", 32'(stat_txn_cnt), 32'd1);
    check("stat_to_cnt",  32'(stat_to_cnt),  32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
